kmkz_dbus_arbiter: RTL and testbench
====================================

Name: kmkz_dbus_arbiter

Overview: Arbitrates the single AHB-Lite data-bus master port between the execute-stage load/store port (core) and a debug/system-control master (dbg). Issues one transfer at a time with AHB address/data phases, and overlaps a new address phase with the completing data phase. Generates the core's dm_ready and the registered load-return data for writeback. Sits between the execute stage, the debug unit and the system AHB interconnect.

Parameters:
STARVE_LIMIT, 4, consecutive core grants while dbg_req_i is pending, after which dbg is granted next (range 1..15).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
dm_addr_i  in  32  core byte address
dm_data_s_i  in  32  core store data, already lane-replicated
dm_data_select_i  in  4  core byte-lane select
dm_load_i  in  1  core load request
dm_store_i  in  1  core store request
dm_ready_o  out  1  core request accepted this cycle
dm_load_done_o  out  1  registered pulse: core load data valid
dm_data_l_o  out  32  registered core load data (raw bus word)
dbg_req_i  in  1  debug request, held until dbg_ack_o
dbg_we_i  in  1  debug write
dbg_addr_i  in  32  debug address
dbg_size_i  in  2  HSIZE encoding for debug
dbg_wdata_i  in  32  debug write data
dbg_ack_o  out  1  pulse: debug transfer complete
dbg_rdata_o  out  32  debug read data, valid with dbg_ack_o
haddr_o  out  32  AHB address
htrans_o  out  2  AHB transfer type (IDLE=00, NONSEQ=10 only)
hwrite_o  out  1  AHB write
hsize_o  out  3  AHB size
hwdata_o  out  32  AHB write data (data phase)
hrdata_i  in  32  AHB read data
hready_i  in  1  AHB ready
hresp_i  in  1  AHB error response

Behaviour:
- Reset: clk_i; rst_i asynchronous, active-low. While rst_i is low, all outputs are 0, the state is IDLE and the starve counter is 0. Asserting reset mid-transfer abandons the transfer with no ack or done.
- Phase state: IDLE, DATA_CORE, DATA_DBG. Stored per data phase: write flag, write data, read flag.
- Bus free = (state==IDLE) || hready_i.
- Grant, evaluated only when the bus is free:
  - Core wins if a core request is present and !(dbg_req_i && starve_cnt==STARVE_LIMIT).
  - Otherwise dbg wins if dbg_req_i is high and dbg is not already in its own completing data phase.
- Core request = dm_load_i|dm_store_i; dm_store_i takes precedence if both are high.
- dm_ready_o = core granted. When no core request is present, dm_ready_o = bus free, so the execute stage never stalls needlessly.
- Address phase, combinational in the grant cycle: htrans_o=NONSEQ, with haddr_o, hwrite_o, hsize_o from the winner. With no grant, htrans_o=IDLE and address/control hold their last values.
- Core hsize_o derived from dm_data_select_i: 1111→010; 0011/1100→001; one-hot→000; any other value→010.
- On a grant, the next state is DATA_CORE or DATA_DBG. If the bus is free with no grant, the next state is IDLE. If hready_i is low in a data phase, the state is held.
- hwdata_o is driven from the latched write data throughout the data phase; it is 0 otherwise.
- Data phase completes when hready_i is high:
  - Core read: next cycle dm_load_done_o=1 and dm_data_l_o=hrdata_i.
  - Dbg: same-cycle dbg_ack_o=1 and dbg_rdata_o=hrdata_i (0 for writes).
- Starve counter: increments, saturating, on each core grant while dbg_req_i is high; clears on a dbg grant or when dbg_req_i is low.
- dbg_req_i must stay high until dbg_ack_o. The ack cycle cannot re-grant the same request.

Optional Feature:
KMKZ_DBUS_ERR_EN.
- Defined:
  - Extra output bus_err_o (1 bit), set to 1 for one cycle, registered, when hresp_i=1 with hready_i=1 in a data phase. The owner's done/ack still fires.
  - htrans_o is forced to IDLE in the first error cycle (hresp_i=1, hready_i=0); any grant in that cycle is suppressed and dm_ready_o=0.
- Undefined: hresp_i is ignored; the port is present but unused.

Decomposition:
- Shared package kmkz_dbus_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ
  - HSIZE_B/H/W
  - state encodings ST_IDLE/ST_DCORE/ST_DDBG
- One sub-module, kmkz_dbus_size_dec: dm_data_select to hsize, combinational.
- The arbitration FSM and starve counter stay in the top module.

Test Plan:
- Core load 0x100, select 1111, hready_i=1, hrdata_i=0xDEADBEEF → cycle0: htrans_o=10, hsize_o=010, dm_ready_o=1; cycle2: dm_load_done_o=1, dm_data_l_o=0xDEADBEEF.
- Core store byte 0x103, select 1000, data 0x55555555, hready_i low for 2 cycles → hsize_o=000, haddr_o=0x103; hwdata_o=0x55555555 for 3 data cycles; a second core request shows dm_ready_o=0 until hready_i rises.
- Core request every cycle plus dbg_req_i held, STARVE_LIMIT=4 → 4 core grants, then dbg granted with dm_ready_o=0; dbg_ack_o arrives one cycle later; the core resumes.
- Dbg write 0x2000=0x12345678 on an idle bus → htrans_o=10, hwrite_o=1; next cycle hwdata_o=0x12345678 and dbg_ack_o=1.
- rst_i low during a DATA_CORE wait state → all outputs 0 immediately; no dm_load_done_o after release.
- With KMKZ_DBUS_ERR_EN: hresp_i=1 for two cycles (hready_i 0 then 1) → htrans_o=00 in the first cycle, bus_err_o=1 the cycle after the second.

Source files
------------

// File: rtl/kmkz_dbus_pkg.sv
// Shared constants and state encoding for the data-bus arbiter.
package kmkz_dbus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DCORE = 2'd1,
    ST_DDBG  = 2'd2
  } state_e;

endpackage

// File: rtl/kmkz_dbus_if.sv
// Data-bus arbiter signal bundle: core load/store port, debug master port
// and the AHB-Lite master port. Suffixes are from the arbiter's point of view.
// master: arbiter side. slave: environment (core, debug unit, interconnect).
// bus_err_o exists only when KMKZ_DBUS_ERR_EN is defined.
interface kmkz_dbus_if;

  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic        dm_load_done_o;
  logic [31:0] dm_data_l_o;

  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [31:0] dbg_addr_i;
  logic [1:0]  dbg_size_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;

  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [31:0] hwdata_o;
  logic [31:0] hrdata_i;
  logic        hready_i;
  logic        hresp_i;
`ifdef KMKZ_DBUS_ERR_EN
  logic        bus_err_o;
`endif

  modport master (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output dm_ready_o, dm_load_done_o, dm_data_l_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_size_i, dbg_wdata_i,
    output dbg_ack_o, dbg_rdata_o,
    output haddr_o, htrans_o, hwrite_o, hsize_o, hwdata_o,
`ifdef KMKZ_DBUS_ERR_EN
    output bus_err_o,
`endif
    input  hrdata_i, hready_i, hresp_i
  );

  modport slave (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  dm_ready_o, dm_load_done_o, dm_data_l_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_size_i, dbg_wdata_i,
    input  dbg_ack_o, dbg_rdata_o,
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hwdata_o,
`ifdef KMKZ_DBUS_ERR_EN
    input  bus_err_o,
`endif
    output hrdata_i, hready_i, hresp_i
  );

endinterface

// File: rtl/kmkz_dbus_size_dec.sv
// Core byte-lane select to AHB HSIZE.
//   dm_data_select_i : 4-bit lane select
//   hsize_o          : 1111 -> word, 0011/1100 -> half, one-hot -> byte,
//                      anything else -> word
module kmkz_dbus_size_dec
  import kmkz_dbus_pkg::*;
(
  input  logic [3:0] dm_data_select_i,
  output logic [2:0] hsize_o
);

  always_comb begin
    hsize_o = HSIZE_W;
    unique case (dm_data_select_i)
      4'b1111:                         hsize_o = HSIZE_W;
      4'b0011, 4'b1100:                hsize_o = HSIZE_H;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000:                hsize_o = HSIZE_B;
      default:                         hsize_o = HSIZE_W;
    endcase
  end

endmodule

// File: rtl/kmkz_dbus_arbiter.sv
// Arbitrates the AHB-Lite data-bus master port between the core load/store
// port and the debug master. One transfer at a time; a new address phase
// overlaps the completing data phase.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : kmkz_dbus_if.master (core, debug and AHB signals)
// Optional: KMKZ_DBUS_ERR_EN adds bus_err_o and idles HTRANS in the first
// error-response cycle; otherwise hresp_i is ignored.
module kmkz_dbus_arbiter
  import kmkz_dbus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
)(
  input  logic       clk_i,
  input  logic       rst_i,
  kmkz_dbus_if.master bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        load_done_q, load_done_d;
  logic [31:0] load_data_q, load_data_d;

  logic        bus_free, err_hold, core_req, core_gnt, dbg_gnt, complete;
  logic [2:0]  core_hsize;
  logic [1:0]  htrans;
  logic        dm_ready, dbg_ack;
  logic [31:0] dbg_rdata, hwdata;

  kmkz_dbus_size_dec u_size_dec (
    .dm_data_select_i (bus.dm_data_select_i),
    .hsize_o          (core_hsize)
  );

`ifdef KMKZ_DBUS_ERR_EN
  logic bus_err_q, bus_err_d;
  assign err_hold = (state_q != ST_IDLE) && bus.hresp_i && !bus.hready_i;
`else
  logic hresp_unused;
  assign hresp_unused = bus.hresp_i;
  assign err_hold     = 1'b0;
`endif

  always_comb begin
    // Gating with rst_i keeps every combinational output at 0 during reset.
    bus_free    = rst_i && ((state_q == ST_IDLE) || bus.hready_i);
    core_req    = bus.dm_load_i || bus.dm_store_i;
    core_gnt    = bus_free && !err_hold && core_req &&
                  !(bus.dbg_req_i && (starve_q == LIMIT));
    // Debug cannot be re-granted in the cycle its own data phase completes.
    dbg_gnt     = bus_free && !err_hold && !core_gnt && bus.dbg_req_i &&
                  (state_q != ST_DDBG);
    dm_ready    = core_req ? core_gnt : (bus_free && !err_hold);
    complete    = (state_q != ST_IDLE) && bus.hready_i;

    state_d     = state_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    htrans      = HTRANS_IDLE;

    if (core_gnt) begin
      state_d  = ST_DCORE;
      htrans   = HTRANS_NONSEQ;
      haddr_d  = bus.dm_addr_i;
      hwrite_d = bus.dm_store_i;
      hsize_d  = core_hsize;
      wr_d     = bus.dm_store_i;
      rd_d     = !bus.dm_store_i;
      wdata_d  = bus.dm_data_s_i;
    end else if (dbg_gnt) begin
      state_d  = ST_DDBG;
      htrans   = HTRANS_NONSEQ;
      haddr_d  = bus.dbg_addr_i;
      hwrite_d = bus.dbg_we_i;
      hsize_d  = {1'b0, bus.dbg_size_i};
      wr_d     = bus.dbg_we_i;
      rd_d     = !bus.dbg_we_i;
      wdata_d  = bus.dbg_wdata_i;
    end else if (bus_free) begin
      state_d  = ST_IDLE;
    end

    if (dbg_gnt || !bus.dbg_req_i) begin
      starve_d = '0;
    end else if (core_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end

    hwdata      = ((state_q != ST_IDLE) && wr_q) ? wdata_q : '0;
    dbg_ack     = complete && (state_q == ST_DDBG);
    dbg_rdata   = (dbg_ack && rd_q) ? bus.hrdata_i : '0;
    load_done_d = complete && (state_q == ST_DCORE) && rd_q;
    load_data_d = load_done_d ? bus.hrdata_i : load_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      load_done_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      load_done_q <= load_done_d;
      load_data_q <= load_data_d;
    end
  end

`ifdef KMKZ_DBUS_ERR_EN
  assign bus_err_d = complete && bus.hresp_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) bus_err_q <= 1'b0;
    else        bus_err_q <= bus_err_d;
  end

  assign bus.bus_err_o = bus_err_q;
`endif

  assign bus.dm_ready_o     = dm_ready;
  assign bus.dm_load_done_o = load_done_q;
  assign bus.dm_data_l_o    = load_data_q;
  assign bus.dbg_ack_o      = dbg_ack;
  assign bus.dbg_rdata_o    = dbg_rdata;
  assign bus.haddr_o        = haddr_d;
  assign bus.htrans_o       = htrans;
  assign bus.hwrite_o       = hwrite_d;
  assign bus.hsize_o        = hsize_d;
  assign bus.hwdata_o       = hwdata;

endmodule

// File: tb/tb_kmkz_dbus_arbiter.sv
// Scoreboard bench for kmkz_dbus_arbiter: stimulus pushes expected address
// phases, load returns and debug acks; a negedge monitor pops and compares.
module tb_kmkz_dbus_arbiter;
  import kmkz_dbus_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
  } aph_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  aph_t        exp_aph_q[$];
  logic [31:0] exp_load_q[$];
  logic [31:0] exp_dbg_q[$];

  kmkz_dbus_if bus_if ();

  kmkz_dbus_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_aph(input logic [31:0] a, input logic w, input logic [2:0] s);
    aph_t e;
    e.addr = a;
    e.wr   = w;
    e.size = s;
    exp_aph_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_htrans"},    32'(bus_if.htrans_o), 32'd0);
    check({tag, "_haddr"},     bus_if.haddr_o, 32'd0);
    check({tag, "_hwrite"},    32'(bus_if.hwrite_o), 32'd0);
    check({tag, "_hsize"},     32'(bus_if.hsize_o), 32'd0);
    check({tag, "_hwdata"},    bus_if.hwdata_o, 32'd0);
    check({tag, "_dm_ready"},  32'(bus_if.dm_ready_o), 32'd0);
    check({tag, "_dbg_ack"},   32'(bus_if.dbg_ack_o), 32'd0);
    check({tag, "_dbg_rdata"}, bus_if.dbg_rdata_o, 32'd0);
    check({tag, "_load_done"}, 32'(bus_if.dm_load_done_o), 32'd0);
    check({tag, "_data_l"},    bus_if.dm_data_l_o, 32'd0);
  endtask

  // Monitor: every observed address phase, load return and debug ack must
  // match the oldest expectation in its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.htrans_o == HTRANS_NONSEQ) begin
        if (exp_aph_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_aph: got haddr 0x%08h, expected no transfer (t=%0t)",
                   bus_if.haddr_o, $time);
        end else begin
          aph_t e;
          e = exp_aph_q.pop_front();
          check("aph_haddr",  bus_if.haddr_o, e.addr);
          check("aph_hwrite", 32'(bus_if.hwrite_o), 32'(e.wr));
          check("aph_hsize",  32'(bus_if.hsize_o), 32'(e.size));
        end
      end
      if (bus_if.dm_load_done_o) begin
        if (exp_load_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load_done: got data 0x%08h, expected no done (t=%0t)",
                   bus_if.dm_data_l_o, $time);
        end else begin
          check("load_data", bus_if.dm_data_l_o, exp_load_q.pop_front());
        end
      end
      if (bus_if.dbg_ack_o) begin
        if (exp_dbg_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_dbg_ack: got rdata 0x%08h, expected no ack (t=%0t)",
                   bus_if.dbg_rdata_o, $time);
        end else begin
          check("dbg_rdata", bus_if.dbg_rdata_o, exp_dbg_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected stimulus to finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus_if.dm_addr_i        = '0;
    bus_if.dm_data_s_i      = '0;
    bus_if.dm_data_select_i = '0;
    bus_if.dm_load_i        = 1'b0;
    bus_if.dm_store_i       = 1'b0;
    bus_if.dbg_req_i        = 1'b0;
    bus_if.dbg_we_i         = 1'b0;
    bus_if.dbg_addr_i       = '0;
    bus_if.dbg_size_i       = '0;
    bus_if.dbg_wdata_i      = '0;
    bus_if.hrdata_i         = '0;
    bus_if.hready_i         = 1'b1;
    bus_if.hresp_i          = 1'b0;

    // A pending core request must not leak through while in reset.
    bus_if.dm_load_i        = 1'b1;
    bus_if.dm_addr_i        = 32'h100;
    bus_if.dm_data_select_i = 4'b1111;
    #2;
    check_all_zero("rst");
    bus_if.dm_load_i = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Core word load.
    cyc();
    bus_if.dm_load_i        = 1'b1;
    bus_if.dm_addr_i        = 32'h100;
    bus_if.dm_data_select_i = 4'b1111;
    bus_if.hrdata_i         = 32'hDEADBEEF;
    push_aph(32'h100, 1'b0, HSIZE_W);
    exp_load_q.push_back(32'hDEADBEEF);
    smp();
    check("t1_dm_ready", 32'(bus_if.dm_ready_o), 32'd1);
    check("t1_htrans", 32'(bus_if.htrans_o), 32'(HTRANS_NONSEQ));
    cyc();
    bus_if.dm_load_i = 1'b0;
    smp();
    check("t1_hwdata_read", bus_if.hwdata_o, 32'd0);
    cyc();
    smp();
    check("t1_load_done", 32'(bus_if.dm_load_done_o), 32'd1);

    // Core byte store with two wait states, second request stalled behind it.
    cyc();
    bus_if.dm_store_i       = 1'b1;
    bus_if.dm_addr_i        = 32'h103;
    bus_if.dm_data_select_i = 4'b1000;
    bus_if.dm_data_s_i      = 32'h55555555;
    push_aph(32'h103, 1'b1, HSIZE_B);
    smp();
    check("t2_dm_ready_0", 32'(bus_if.dm_ready_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus_if.dm_store_i       = 1'b0;
      bus_if.dm_load_i        = 1'b1;
      bus_if.dm_addr_i        = 32'h200;
      bus_if.dm_data_select_i = 4'b0011;
      bus_if.hready_i         = 1'b0;
      smp();
      check("t2_dm_ready_wait", 32'(bus_if.dm_ready_o), 32'd0);
      check("t2_hwdata_wait", bus_if.hwdata_o, 32'h55555555);
      check("t2_htrans_wait", 32'(bus_if.htrans_o), 32'(HTRANS_IDLE));
    end
    cyc();
    bus_if.hready_i = 1'b1;
    push_aph(32'h200, 1'b0, HSIZE_H);
    smp();
    check("t2_dm_ready_rise", 32'(bus_if.dm_ready_o), 32'd1);
    check("t2_hwdata_last", bus_if.hwdata_o, 32'h55555555);
    cyc();
    bus_if.dm_load_i = 1'b0;
    bus_if.hrdata_i  = 32'h0BADC0DE;
    exp_load_q.push_back(32'h0BADC0DE);
    smp();
    check("t2_hwdata_read", bus_if.hwdata_o, 32'd0);
    cyc();
    smp();

    // Starvation: core every cycle with debug pending; debug wins the fifth slot.
    bus_if.dbg_we_i   = 1'b0;
    bus_if.dbg_addr_i = 32'h4000;
    bus_if.dbg_size_i = 2'b10;
    bus_if.dm_data_select_i = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      cyc();
      bus_if.hrdata_i = 32'hA0000000 + 32'(k);
      if (k < 6) begin
        bus_if.dm_load_i = 1'b1;
        bus_if.dbg_req_i = 1'b1;
        bus_if.dm_addr_i = (k < 4) ? 32'h300 + 32'(4 * k) : 32'h310;
      end else begin
        bus_if.dm_load_i = 1'b0;
        bus_if.dbg_req_i = 1'b0;
      end
      if (k < 4 || k == 5) push_aph(bus_if.dm_addr_i, 1'b0, HSIZE_W);
      if (k == 4) push_aph(32'h4000, 1'b0, HSIZE_W);
      if (k >= 1 && k != 5) exp_load_q.push_back(32'hA0000000 + 32'(k));
      if (k == 5) exp_dbg_q.push_back(32'hA0000005);
      smp();
      if (k < 6) check("t3_dm_ready", 32'(bus_if.dm_ready_o), (k == 4) ? 32'd0 : 32'd1);
      if (k == 5) check("t3_dbg_ack", 32'(bus_if.dbg_ack_o), 32'd1);
    end
    cyc();
    smp();

    // Debug write on an idle bus; write ack returns zero read data.
    cyc();
    bus_if.dbg_req_i   = 1'b1;
    bus_if.dbg_we_i    = 1'b1;
    bus_if.dbg_addr_i  = 32'h2000;
    bus_if.dbg_size_i  = 2'b10;
    bus_if.dbg_wdata_i = 32'h12345678;
    push_aph(32'h2000, 1'b1, HSIZE_W);
    smp();
    check("t4_htrans", 32'(bus_if.htrans_o), 32'(HTRANS_NONSEQ));
    check("t4_hwrite", 32'(bus_if.hwrite_o), 32'd1);
    check("t4_dm_ready_idle", 32'(bus_if.dm_ready_o), 32'd1);
    cyc();
    bus_if.hrdata_i = 32'hFFFFFFFF;
    exp_dbg_q.push_back(32'd0);
    smp();
    check("t4_hwdata", bus_if.hwdata_o, 32'h12345678);
    check("t4_dbg_ack", 32'(bus_if.dbg_ack_o), 32'd1);
    check("t4_no_regrant", 32'(bus_if.htrans_o), 32'(HTRANS_IDLE));
    cyc();
    bus_if.dbg_req_i = 1'b0;
    bus_if.dbg_we_i  = 1'b0;
    smp();
    check("t4_ack_pulse", 32'(bus_if.dbg_ack_o), 32'd0);

    // Reset during a core-load wait state abandons the transfer.
    cyc();
    bus_if.dm_load_i        = 1'b1;
    bus_if.dm_addr_i        = 32'h500;
    bus_if.dm_data_select_i = 4'b0001;
    push_aph(32'h500, 1'b0, HSIZE_B);
    smp();
    cyc();
    bus_if.dm_load_i = 1'b0;
    bus_if.hready_i  = 1'b0;
    smp();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5");
    cyc();
    cyc();
    rst_n = 1'b1;
    bus_if.hready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("t5_no_load_done", 32'(bus_if.dm_load_done_o), 32'd0);
      check("t5_htrans_idle", 32'(bus_if.htrans_o), 32'(HTRANS_IDLE));
      cyc();
    end

`ifdef KMKZ_DBUS_ERR_EN
    // Two-cycle error response on a core store.
    bus_if.dm_store_i       = 1'b1;
    bus_if.dm_addr_i        = 32'h600;
    bus_if.dm_data_select_i = 4'b1111;
    bus_if.dm_data_s_i      = 32'h77777777;
    push_aph(32'h600, 1'b1, HSIZE_W);
    smp();
    cyc();
    bus_if.dm_store_i = 1'b0;
    bus_if.dm_load_i  = 1'b1;
    bus_if.dm_addr_i  = 32'h604;
    bus_if.hresp_i    = 1'b1;
    bus_if.hready_i   = 1'b0;
    smp();
    check("err_htrans_first", 32'(bus_if.htrans_o), 32'(HTRANS_IDLE));
    check("err_dm_ready_first", 32'(bus_if.dm_ready_o), 32'd0);
    check("err_bus_err_pre", 32'(bus_if.bus_err_o), 32'd0);
    cyc();
    bus_if.dm_load_i = 1'b0;
    bus_if.hready_i  = 1'b1;
    smp();
    check("err_bus_err_second", 32'(bus_if.bus_err_o), 32'd0);
    cyc();
    bus_if.hresp_i = 1'b0;
    smp();
    check("err_bus_err_set", 32'(bus_if.bus_err_o), 32'd1);
    cyc();
    smp();
    check("err_bus_err_pulse", 32'(bus_if.bus_err_o), 32'd0);
    cyc();
`endif

    cyc();
    cyc();
    check("end_aph_queue", 32'(exp_aph_q.size()), 32'd0);
    check("end_load_queue", 32'(exp_load_q.size()), 32'd0);
    check("end_dbg_queue", 32'(exp_dbg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
